display_scan: RTL and testbench

- Time-multiplexed scanner for an N-digit common-anode 7-segment display.
- Latches a packed hex value and decimal-point mask, then steps through the digits at a programmable refresh rate.
- For each digit it presents the active nibble, the active-low anode enable and the active-low decimal point.
- Sits directly upstream of the hex-to-segment decoder, which consumes digit_hex; the anode and dp outputs go straight to the board pins.

---
 rtl/display_scan.sv | 68 ++++++
 tb/tb_display_scan.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// display_scan: time-multiplexed N-digit 7-segment scanner with leading-zero blanking
module display_scan #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        load,
  input  logic [4*N_DIGITS-1:0]       value_in,
  input  logic [N_DIGITS-1:0]         dp_in,
  input  logic                        blank_lz,
  input  logic                        enable,
  output logic [3:0]                  digit_hex,
  output logic [N_DIGITS-1:0]         anode_n,
  output logic                        dp_n,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx
);
  localparam int IW = $clog2(N_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  logic [PW-1:0]         pres_q, pres_d;
  logic [IW-1:0]         idx_q, idx_d, msd;
  logic [4*N_DIGITS-1:0] val_q, val_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d, anode_d;
  logic [3:0]            hex_d;
  logic                  dpn_d, slot_end, on;
  assign digit_idx = idx_q;
  // Slot prescaler and digit counter advance only while scanning is enabled
  always_comb begin
    slot_end = pres_q == PW'(REFRESH_DIV - 1);
    pres_d   = !enable ? pres_q : slot_end ? '0 : pres_q + 1'b1;
    idx_d    = !(enable && slot_end) ? idx_q : idx_q == IW'(N_DIGITS - 1) ? '0 : idx_q + 1'b1;
    val_d    = load ? value_in : val_q;
    dp_d     = load ? dp_in : dp_q;
  end
  // Highest nonzero nibble bounds which digits leading-zero blanking may darken
  always_comb begin
    msd = '0;
    for (int k = 0; k < N_DIGITS; k++)
      if (val_q[4*k+:4] != 4'h0) msd = IW'(k);
  end
  // Pres==0 is a dark gap so two anodes never overlap across a slot change
  always_comb begin
    on      = enable && pres_q != '0 && !(blank_lz && idx_q > msd);
    anode_d = on ? ~(N_DIGITS'(1) << idx_q) : '1;
    hex_d   = val_q[4*idx_q+:4];
    dpn_d   = on ? ~dp_q[idx_q] : 1'b1;
  end
  // State and registered pin outputs; reset darkens the display at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pres_q    <= '0;
      idx_q     <= '0;
      val_q     <= '0;
      dp_q      <= '0;
      anode_n   <= '1;
      digit_hex <= 4'h0;
      dp_n      <= 1'b1;
    end else begin
      pres_q    <= pres_d;
      idx_q     <= idx_d;
      val_q     <= val_d;
      dp_q      <= dp_d;
      anode_n   <= anode_d;
      digit_hex <= hex_d;
      dp_n      <= dpn_d;
    end
  end
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed bench for display_scan with a slot-arithmetic reference model
module tb_display_scan;
  localparam int N = 8;
  localparam int R = 4;
  logic        clk = 1'b0;
  logic        reset_n, load, blank_lz, enable;
  logic [31:0] value_in;
  logic [7:0]  dp_in;
  logic [3:0]  digit_hex;
  logic [7:0]  anode_n;
  logic        dp_n;
  logic [2:0]  digit_idx;
  int vectors = 0;
  int miss = 0;

  display_scan #(.N_DIGITS(N), .REFRESH_DIV(R)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .value_in(value_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .enable(enable), .digit_hex(digit_hex), .anode_n(anode_n),
    .dp_n(dp_n), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  // Reference: t counts enabled edges since reset; slot = t/R, phase = t%R
  int          t;
  logic [31:0] mval;
  logic [7:0]  mdp, e_an;
  logic [3:0]  e_hex;
  logic        e_dp;

  function automatic bit lit(int tt, logic [31:0] v, bit en, bit blz);
    int msd = 0;
    for (int k = 0; k < N; k++) if (v[4*k+:4] != 4'h0) msd = k;
    return en && (tt % R) != 0 && !(blz && (tt / R) % N > msd);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t <= 0; mval <= '0; mdp <= '0; e_an <= 8'hFF; e_hex <= 4'h0; e_dp <= 1'b1;
    end else begin
      e_an  <= lit(t, mval, enable, blank_lz) ? ~(8'd1 << ((t / R) % N)) : 8'hFF;
      e_hex <= mval[4*((t / R) % N)+:4];
      e_dp  <= lit(t, mval, enable, blank_lz) ? ~mdp[(t / R) % N] : 1'b1;
      t     <= enable ? (t + 1) % (N * R) : t;
      if (load) begin
        mval <= value_in;
        mdp  <= dp_in;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_anode", 32'(anode_n), 32'(e_an));
    chk("model_hex", 32'(digit_hex), 32'(e_hex));
    chk("model_dp", 32'(dp_n), 32'(e_dp));
    chk("model_idx", 32'(digit_idx), 32'((t / R) % N));
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_slot(int idx);
    bit found = 0;
    for (int c = 0; c < 80 && !found; c++) begin
      @(negedge clk);
      found = (digit_idx == 3'(idx)) && (anode_n == 8'hFF);
    end
    chk($sformatf("wait_slot%0d", idx), 32'(found), 32'd1);
  endtask

  task automatic load_val(logic [31:0] v, logic [7:0] d);
    value_in = v; dp_in = d; load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    int n_a, n_b, bad;
    reset_n = 1'b0; load = 1'b0; blank_lz = 1'b0; enable = 1'b1; value_in = '0; dp_in = '0;
    tick(2);
    chk("rst_anode", 32'(anode_n), 32'hFF);
    chk("rst_hex", 32'(digit_hex), 32'h0);
    chk("rst_dp", 32'(dp_n), 32'h1);
    chk("rst_idx", 32'(digit_idx), 32'h0);
    // basic scan
    reset_n = 1'b1;
    load_val(32'h1234ABCD, 8'h00);
    chk("scan_e1_dark", 32'(anode_n), 32'hFF);
    tick(1);
    chk("scan_d0_anode", 32'(anode_n), 32'hFE);
    chk("scan_d0_hex", 32'(digit_hex), 32'hD);
    tick(3);
    chk("scan_gap", 32'(anode_n), 32'hFF);
    tick(1);
    chk("scan_d1_anode", 32'(anode_n), 32'hFD);
    chk("scan_d1_hex", 32'(digit_hex), 32'hC);
    tick(28);
    chk("scan_wrap_anode", 32'(anode_n), 32'hFE);
    chk("scan_wrap_hex", 32'(digit_hex), 32'hD);
    // leading-zero blanking
    blank_lz = 1'b1;
    load_val(32'h00000050, 8'h00);
    tick(1);
    n_a = 0; n_b = 0; bad = 0;
    for (int c = 0; c < 64; c++) begin
      tick(1);
      if (anode_n == 8'hFE && digit_hex == 4'h0) n_a++;
      if (anode_n == 8'hFD && digit_hex == 4'h5) n_b++;
      if (!(anode_n inside {8'hFF, 8'hFE, 8'hFD})) bad++;
    end
    chk("lz50_fe", 32'(n_a), 32'd6);
    chk("lz50_fd", 32'(n_b), 32'd6);
    chk("lz50_other", 32'(bad), 32'd0);
    load_val(32'h0, 8'h00);
    tick(1);
    n_a = 0; bad = 0;
    for (int c = 0; c < 64; c++) begin
      tick(1);
      if (anode_n == 8'hFE && digit_hex == 4'h0) n_a++;
      if (!(anode_n inside {8'hFF, 8'hFE})) bad++;
    end
    chk("lz0_fe", 32'(n_a), 32'd6);
    chk("lz0_other", 32'(bad), 32'd0);
    // decimal point
    blank_lz = 1'b0;
    load_val(32'h0, 8'h04);
    tick(1);
    n_a = 0; bad = 0;
    for (int c = 0; c < 64; c++) begin
      tick(1);
      if (!dp_n) n_a++;
      if (!dp_n && anode_n != 8'hFB) bad++;
    end
    chk("dp_low_cycles", 32'(n_a), 32'd6);
    chk("dp_wrong_digit", 32'(bad), 32'd0);
    blank_lz = 1'b1;
    tick(1);
    n_a = 0;
    for (int c = 0; c < 64; c++) begin
      tick(1);
      if (!dp_n) n_a++;
    end
    chk("dp_blanked", 32'(n_a), 32'd0);
    // enable freeze
    blank_lz = 1'b0;
    load_val(32'h1234ABCD, 8'h00);
    wait_slot(5);
    tick(1);
    chk("frz_lit", 32'(anode_n), 32'hDF);
    enable = 1'b0;
    tick(1);
    chk("frz_dark", 32'(anode_n), 32'hFF);
    chk("frz_idx", 32'(digit_idx), 32'd5);
    tick(9);
    chk("frz_hold_dark", 32'(anode_n), 32'hFF);
    chk("frz_hold_idx", 32'(digit_idx), 32'd5);
    enable = 1'b1;
    tick(1);
    chk("frz_resume", 32'(anode_n), 32'hDF);
    chk("frz_resume_hex", 32'(digit_hex), 32'h3);
    tick(1);
    chk("frz_resume2", 32'(anode_n), 32'hDF);
    tick(1);
    chk("frz_gap", 32'(anode_n), 32'hFF);
    tick(1);
    chk("frz_next", 32'(anode_n), 32'hBF);
    chk("frz_next_hex", 32'(digit_hex), 32'h2);
    chk("frz_next_idx", 32'(digit_idx), 32'd6);
    // reset mid-scan
    wait_slot(5);
    tick(1);
    #2 reset_n = 1'b0;
    #1;
    chk("amid_anode", 32'(anode_n), 32'hFF);
    chk("amid_hex", 32'(digit_hex), 32'h0);
    chk("amid_dp", 32'(dp_n), 32'h1);
    chk("amid_idx", 32'(digit_idx), 32'h0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    tick(1);
    chk("rel_e1", 32'(anode_n), 32'hFF);
    tick(1);
    chk("rel_e2_anode", 32'(anode_n), 32'hFE);
    chk("rel_e2_hex", 32'(digit_hex), 32'h0);
    // load on wrap, then load mid-slot
    load_val(32'h1234ABCD, 8'h00);
    wait_slot(2);
    tick(2);
    chk("wrap_pre", 32'(anode_n), 32'hFB);
    value_in = 32'h12349BCD; load = 1'b1;
    tick(1);
    load = 1'b0;
    chk("wrap_edge_anode", 32'(anode_n), 32'hFB);
    chk("wrap_edge_hex", 32'(digit_hex), 32'hB);
    chk("wrap_edge_idx", 32'(digit_idx), 32'd3);
    tick(1);
    chk("wrap_gap_hex", 32'(digit_hex), 32'h9);
    tick(1);
    chk("wrap_lit_anode", 32'(anode_n), 32'hF7);
    chk("wrap_lit_hex", 32'(digit_hex), 32'h9);
    value_in = 32'h12347BCD; load = 1'b1;
    tick(1);
    load = 1'b0;
    chk("ld_e1_hex", 32'(digit_hex), 32'h9);
    tick(1);
    chk("ld_e2_hex", 32'(digit_hex), 32'h7);
    chk("ld_e2_anode", 32'(anode_n), 32'hF7);
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
